msk_gf_mul_hpc3_pipe: RTL

MSK_GF_MUL_HPC3_PIPE -- requirements
Module: msk_gf_mul_hpc3_pipe

---
 rtl/msk_gf_mul_hpc3_pipe.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/msk_gf_mul_hpc3_pipe.sv
// Masked GF(2^W) multiplier, HPC3 gadget, one register stage.
// Shares are bit-interleaved: bit (c*W+w)*d+s is share s of bit w, channel c.

module msk_gf_mul_hpc3_gfmul #(
   parameter int W = 2
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] p
);
   // x^2+x+1 and x^4+x+1 share the same low-order reduction term
   localparam logic [W-1:0] POLY = W'(3);

   always_comb begin
      p = '0;
      for (int i = W - 1; i >= 0; i--) begin
         p = {p[W-2:0], 1'b0} ^ (p[W-1] ? POLY : '0) ^ (b[i] ? a : '0);
      end
   end
endmodule

module msk_gf_mul_hpc3_pipe #(
   parameter int d        = 2,
   parameter int W        = 2,
   parameter int NCH      = 1,
   parameter int PREV_INT = 0,
   parameter int NR       = W * d * (d - 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 in_valid,
   input  logic [NCH*W*d-1:0]   ina,
   input  logic [NCH*W*d-1:0]   inb,
   input  logic [NCH*W*d-1:0]   ina_prev,
   input  logic [NCH*NR-1:0]    rnd,
   output logic [NCH*W*d-1:0]   out,
   output logic                 out_valid
);
   localparam int D1 = d - 1;

   logic [W-1:0] a_s   [NCH][d];
   logic [W-1:0] b_s   [NCH][d];
   logic [W-1:0] pa_s  [NCH][d];
   logic [W-1:0] ap_s  [NCH][d];
   logic [W-1:0] a_d   [NCH][d];
   logic [W-1:0] a_q   [NCH][d];
   logic [W-1:0] o_s   [NCH][d];
   logic [W-1:0] r0_s  [NCH][d][D1];
   logic [W-1:0] r1_s  [NCH][d][D1];
   logic [W-1:0] mu_b  [NCH][d][D1];
   logic [W-1:0] mu_p  [NCH][d][D1];
   logic [W-1:0] mv_p  [NCH][d][D1];
   logic [W-1:0] u_d   [NCH][d][D1];
   logic [W-1:0] u_q   [NCH][d][D1];
   logic [W-1:0] vp_d  [NCH][d][D1];
   logic [W-1:0] vp_q  [NCH][d][D1];
   logic         out_valid_d;
   logic         out_valid_q;

   function automatic int pidx(input int i, input int j);
      int lo;
      int hi;
      lo = (i < j) ? i : j;
      hi = (i < j) ? j : i;
      return lo * (2 * d - lo - 1) / 2 + hi - lo - 1;
   endfunction

   always_comb begin
      a_s  = '{default: '0};
      b_s  = '{default: '0};
      pa_s = '{default: '0};
      for (int c = 0; c < NCH; c++)
         for (int w = 0; w < W; w++)
            for (int s = 0; s < d; s++) begin
               a_s[c][s][w]  = ina[(c*W+w)*d+s];
               b_s[c][s][w]  = inb[(c*W+w)*d+s];
               pa_s[c][s][w] = ina_prev[(c*W+w)*d+s];
            end
   end

   always_comb begin
      a_d  = a_s;
      ap_s = '{default: '0};
      for (int c = 0; c < NCH; c++)
         for (int s = 0; s < d; s++)
            ap_s[c][s] = (PREV_INT != 0) ? a_q[c][s] : pa_s[c][s];
   end

   // Pair (i,j) and (j,i) draw the same (r0,r1) so r1 cancels in the sum
   always_comb begin
      int j;
      int base;
      r0_s = '{default: '0};
      r1_s = '{default: '0};
      mu_b = '{default: '0};
      vp_d = '{default: '0};
      for (int c = 0; c < NCH; c++)
         for (int i = 0; i < d; i++)
            for (int k = 0; k < D1; k++) begin
               j    = (k < i) ? k : k + 1;
               base = c * NR + pidx(i, j) * 2 * W;
               r0_s[c][i][k] = rnd[base +: W];
               r1_s[c][i][k] = rnd[base + W +: W];
               mu_b[c][i][k] = (k == 0) ? (b_s[c][i] ^ r0_s[c][i][k])
                                        : r0_s[c][i][k];
               vp_d[c][i][k] = b_s[c][j] ^ r0_s[c][i][k];
            end
   end

   always_comb begin
      u_d = '{default: '0};
      for (int c = 0; c < NCH; c++)
         for (int i = 0; i < d; i++)
            for (int k = 0; k < D1; k++)
               u_d[c][i][k] = mu_p[c][i][k] ^ r1_s[c][i][k];
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      for (genvar i = 0; i < d; i++) begin : g_sh
         for (genvar k = 0; k < D1; k++) begin : g_pr
            msk_gf_mul_hpc3_gfmul #(.W(W)) u_mu (
               .a (a_s[c][i]),
               .b (mu_b[c][i][k]),
               .p (mu_p[c][i][k])
            );
            msk_gf_mul_hpc3_gfmul #(.W(W)) u_mv (
               .a (ap_s[c][i]),
               .b (vp_q[c][i][k]),
               .p (mv_p[c][i][k])
            );
         end
      end
   end

   assign out_valid_d = in_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         u_q         <= '{default: '0};
         vp_q        <= '{default: '0};
         a_q         <= '{default: '0};
         out_valid_q <= 1'b0;
      end else if (en) begin
         u_q         <= u_d;
         vp_q        <= vp_d;
         a_q         <= a_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      o_s = '{default: '0};
      out = '0;
      for (int c = 0; c < NCH; c++)
         for (int i = 0; i < d; i++) begin
            for (int k = 0; k < D1; k++)
               o_s[c][i] = o_s[c][i] ^ u_q[c][i][k] ^ mv_p[c][i][k];
            for (int w = 0; w < W; w++)
               out[(c*W+w)*d+i] = o_s[c][i][w];
         end
   end

   assign out_valid = out_valid_q;
endmodule
